bp_l15_req_engine: RTL and testbench
====================================

Name: bp_l15_req_engine

Overview:
- Request/response engine between the BP-side memory command channel and the L1.5 transducer interface.
- Accepts one BP command at a time and issues it to the L1.5 as a load or store.
- Waits for the matching L1.5 return, then presents one 64-bit response to BP.
- Sits directly upstream of the L1.5 port; every L1.5 return is acked, and unmatched ones are dropped.

Parameters:
- addr_width_p, 40, physical address width
- data_width_p, 64, data word width
- timeout_cycles_p, 1024, WAIT-state cycle limit (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- mem_cmd_v_i  in  1  BP command valid
- mem_cmd_ready_o  out  1  engine can accept a command
- mem_cmd_store_i  in  1  1=store, 0=load
- mem_cmd_nc_i  in  1  non-cacheable
- mem_cmd_size_i  in  2  0=1B, 1=2B, 2=4B, 3=8B
- mem_cmd_addr_i  in  40  byte address
- mem_cmd_data_i  in  64  store data, right-aligned
- mem_resp_v_o  out  1  response valid
- mem_resp_yumi_i  in  1  BP consumes response
- mem_resp_store_o  out  1  response is a store ack
- mem_resp_data_o  out  64  load data, right-aligned, zero-extended
- transducer_l15_val  out  1  request valid
- transducer_l15_rqtype  out  5  00000 load, 00001 store
- transducer_l15_size  out  3  {1'b0, size}
- transducer_l15_address  out  40  latched address
- transducer_l15_data  out  64  size-replicated store data
- transducer_l15_nc  out  1  latched nc
- l15_transducer_ack  in  1  request accepted
- l15_transducer_header_ack  in  1  ignored
- l15_transducer_val  in  1  return valid
- l15_transducer_returntype  in  4  0000 LOAD_RET, 0100 ST_ACK, others unsolicited
- l15_transducer_data_0  in  64  return bytes 0-7 of the 16B block
- l15_transducer_data_1  in  64  return bytes 8-15
- transducer_l15_req_ack  out  1  return consumed
- error_o  out  1  sticky timeout flag

Behaviour:
- Single clock domain. On reset (synchronous, active-low):
  - state=IDLE; all outputs 0; all latches cleared.
  - mem_cmd_ready_o=1 from the first cycle after reset deasserts.
  - Reset mid-transaction abandons the transaction silently.
- Byte lane k is bits [8k+7:8k].
- IDLE:
  - mem_cmd_ready_o=1.
  - On mem_cmd_v_i: latch store, nc, size, addr and data; go to REQ the next cycle.
- REQ:
  - transducer_l15_val=1; address, rqtype, size and nc are driven from the latches and held stable.
  - When l15_transducer_ack=1: deassert val the next cycle and go to WAIT.
  - Ack in the first REQ cycle gives a val pulse exactly 1 cycle wide.
- WAIT:
  - Load with LOAD_RET: select word = addr[3] ? data_1 : data_0. Shift right by addr[2:0]*8, mask to the size, store in the response register, go to RESP.
  - Store with ST_ACK: response data=0, go to RESP.
  - Any other returntype, or a type that mismatches the request: dropped.
- RESP:
  - mem_resp_v_o=1 with stable data.
  - On mem_resp_yumi_i, go to IDLE; mem_cmd_ready_o rises the cycle after yumi, so no back-to-back accept in the yumi cycle.
- transducer_l15_req_ack = l15_transducer_val, combinationally, in every state:
  - Every return is acked in the cycle it is presented.
  - Returns outside WAIT are always dropped.
- Store data replication:
  - size0: 8× byte 0
  - size1: 4× bytes 1:0
  - size2: 2× bytes 3:0
  - size3: unchanged
- Latency:
  - Command accept to val: 1 cycle.
  - Return in WAIT to mem_resp_v_o: 1 cycle.
- Misaligned sizes are not checked; the low address bits pass through unchanged.
- Simultaneous l15_transducer_ack and l15_transducer_val in REQ: the return is acked and dropped, and the state advances to WAIT. The L1.5 never returns in the same cycle it accepts.

Optional Feature:
- Macro: BP_L15_REQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches timeout_cycles_p: error_o=1 (sticky until reset), and the engine goes to RESP with data 0xDEAD_BEEF_DEAD_BEEF so BP never hangs.
- Undefined: no counter; error_o tied 0; WAIT waits indefinitely.

Test Plan:
- Load 8B, addr 0x80_0000_0008:
  - L1.5 acks after 3 cycles; LOAD_RET with data_1=0x1122334455667788.
  - Expect rqtype=00000, size=011, val high exactly 3 cycles, resp data 0x1122334455667788.
- Load 1B, addr 0x...0005:
  - data_0=0x0706050403020100.
  - Expect resp data 0x05; store flag 0.
- Store 2B 0xABCD to addr 0x...0002, nc=1:
  - Expect transducer_l15_data=0xABCDABCDABCDABCD, size=001, nc=1.
  - ST_ACK gives mem_resp_v_o with store=1.
- Unsolicited returns:
  - EVICT_REQ (0011) during WAIT, and another during IDLE.
  - Both acked the same cycle, state unchanged; the subsequent LOAD_RET completes normally.
- Backpressure and reset:
  - Hold mem_resp_yumi_i low 10 cycles: response stable, ready low throughout.
  - Assert reset_n_i=0 during REQ: the next cycle all outputs are 0, and the engine is in IDLE once reset deasserts.
- Timeout (macro defined, timeout_cycles_p=16):
  - No return after ack.
  - At cycle 16 of WAIT: error_o=1 and resp data 0xDEADBEEFDEADBEEF.

Source files
------------

// File: rtl/bp_l15_req_engine_if.sv
// bp_l15_req_engine_if: BP memory command/response channel plus L1.5 transducer channel.
// The engine takes the master modport because it originates L1.5 requests and BP responses.
// The BP core and L1.5 side take the slave modport.
interface bp_l15_req_engine_if #(
    parameter int addr_width_p = 40,
    parameter int data_width_p = 64
);
    // BP command channel
    logic                    mem_cmd_v_i;
    logic                    mem_cmd_ready_o;
    logic                    mem_cmd_store_i;
    logic                    mem_cmd_nc_i;
    logic [1:0]              mem_cmd_size_i;
    logic [addr_width_p-1:0] mem_cmd_addr_i;
    logic [data_width_p-1:0] mem_cmd_data_i;
    // BP response channel
    logic                    mem_resp_v_o;
    logic                    mem_resp_yumi_i;
    logic                    mem_resp_store_o;
    logic [data_width_p-1:0] mem_resp_data_o;
    // L1.5 request channel
    logic                    transducer_l15_val;
    logic [4:0]              transducer_l15_rqtype;
    logic [2:0]              transducer_l15_size;
    logic [addr_width_p-1:0] transducer_l15_address;
    logic [data_width_p-1:0] transducer_l15_data;
    logic                    transducer_l15_nc;
    logic                    l15_transducer_ack;
    logic                    l15_transducer_header_ack;
    // L1.5 return channel
    logic                    l15_transducer_val;
    logic [3:0]              l15_transducer_returntype;
    logic [data_width_p-1:0] l15_transducer_data_0;
    logic [data_width_p-1:0] l15_transducer_data_1;
    logic                    transducer_l15_req_ack;
    // Status
    logic                    error_o;

    modport master (
        input  mem_cmd_v_i, mem_cmd_store_i, mem_cmd_nc_i, mem_cmd_size_i,
               mem_cmd_addr_i, mem_cmd_data_i, mem_resp_yumi_i,
               l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
               l15_transducer_returntype, l15_transducer_data_0, l15_transducer_data_1,
        output mem_cmd_ready_o, mem_resp_v_o, mem_resp_store_o, mem_resp_data_o,
               transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
               transducer_l15_address, transducer_l15_data, transducer_l15_nc,
               transducer_l15_req_ack, error_o
    );

    modport slave (
        output mem_cmd_v_i, mem_cmd_store_i, mem_cmd_nc_i, mem_cmd_size_i,
               mem_cmd_addr_i, mem_cmd_data_i, mem_resp_yumi_i,
               l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
               l15_transducer_returntype, l15_transducer_data_0, l15_transducer_data_1,
        input  mem_cmd_ready_o, mem_resp_v_o, mem_resp_store_o, mem_resp_data_o,
               transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
               transducer_l15_address, transducer_l15_data, transducer_l15_nc,
               transducer_l15_req_ack, error_o
    );
endinterface

// File: rtl/bp_l15_req_engine.sv
// bp_l15_req_engine: single-outstanding engine that turns one BP memory command into an
// L1.5 load/store, waits for the matching return and hands one 64-bit response back to BP.
// Optional WAIT-state watchdog: define BP_L15_REQ_TIMEOUT_EN to enable it. When it is
// undefined, error_o is tied low and WAIT has no time limit.
module bp_l15_req_engine #(
    parameter int addr_width_p     = 40,
    parameter int data_width_p     = 64,
    parameter int timeout_cycles_p = 1024
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    bp_l15_req_engine_if.master bus
);
    localparam logic [4:0]  rqtype_load_lp   = 5'b00000;
    localparam logic [4:0]  rqtype_store_lp  = 5'b00001;
    localparam logic [3:0]  ret_load_lp      = 4'b0000;
    localparam logic [3:0]  ret_st_ack_lp    = 4'b0100;
    localparam logic [63:0] timeout_data_lp  = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam int          lanes_lp         = data_width_p / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                  state_reg;
    logic                    ready_reg;
    logic                    l15_val_reg;
    logic                    resp_v_reg;
    logic                    resp_store_reg;
    logic [data_width_p-1:0] resp_data_reg;
    logic                    store_reg;
    logic                    nc_reg;
    logic [1:0]              size_reg;
    logic [addr_width_p-1:0] addr_reg;
    logic [data_width_p-1:0] store_data_reg;

    logic [data_width_p-1:0] store_data_next;
    logic [data_width_p-1:0] load_word;
    logic [data_width_p-1:0] load_shifted;
    logic [data_width_p-1:0] load_data_next;
    logic                    ret_match;
    logic                    timeout_hit;

    // Store data replication: every byte lane repeats the low 2^size bytes of the command.
    genvar gi;
    generate
        for (gi = 0; gi < lanes_lp; gi++) begin : g_lane
            logic [7:0] lane_byte;
            // Select the source byte for this lane according to the access size.
            always_comb begin
                case (bus.mem_cmd_size_i)
                    2'd0:    lane_byte = bus.mem_cmd_data_i[7:0];
                    2'd1:    lane_byte = bus.mem_cmd_data_i[8*(gi%2) +: 8];
                    2'd2:    lane_byte = bus.mem_cmd_data_i[8*(gi%4) +: 8];
                    default: lane_byte = bus.mem_cmd_data_i[8*gi +: 8];
                endcase
            end
            assign store_data_next[8*gi +: 8] = lane_byte;
        end
    endgenerate

    // Load return: pick the 8B half of the 16B block, then right-align the addressed byte.
    assign load_word    = addr_reg[3] ? bus.l15_transducer_data_1 : bus.l15_transducer_data_0;
    assign load_shifted = load_word >> {addr_reg[2:0], 3'b000};

    // Zero-extend: keep only the bytes covered by the access size.
    always_comb begin
        load_data_next = '0;
        case (size_reg)
            2'd0:    load_data_next[7:0]  = load_shifted[7:0];
            2'd1:    load_data_next[15:0] = load_shifted[15:0];
            2'd2:    load_data_next[31:0] = load_shifted[31:0];
            default: load_data_next       = load_shifted;
        endcase
    end

    // Only a return of the type that answers the outstanding request completes it.
    assign ret_match = bus.l15_transducer_val &&
                       (bus.l15_transducer_returntype == (store_reg ? ret_st_ack_lp : ret_load_lp));

`ifdef BP_L15_REQ_TIMEOUT_EN
    localparam logic [15:0] timeout_lim_lp = 16'(timeout_cycles_p - 1);

    logic [15:0] timeout_count_reg;
    logic        error_reg;

    // Fires in the last allowed WAIT cycle when no matching return has shown up.
    assign timeout_hit = (state_reg == WAIT) && !ret_match && (timeout_count_reg == timeout_lim_lp);

    // Watchdog counter restarts on every WAIT entry; the error flag sticks until reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            timeout_count_reg <= '0;
            error_reg         <= 1'b0;
        end else begin
            if (state_reg == REQ) begin
                timeout_count_reg <= '0;
            end else if (state_reg == WAIT) begin
                timeout_count_reg <= timeout_count_reg + 16'd1;
            end
            if (timeout_hit) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign bus.error_o = error_reg;
    wire unused_ok = bus.l15_transducer_header_ack;
`else
    localparam logic [31:0] timeout_bits_lp = 32'(timeout_cycles_p);

    assign timeout_hit = 1'b0;
    assign bus.error_o = 1'b0;
    wire unused_ok = ^{bus.l15_transducer_header_ack, timeout_bits_lp[0]};
`endif

    // Command/response sequencing; every output below comes straight from these registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg      <= IDLE;
            ready_reg      <= 1'b0;
            l15_val_reg    <= 1'b0;
            resp_v_reg     <= 1'b0;
            resp_store_reg <= 1'b0;
            resp_data_reg  <= '0;
            store_reg      <= 1'b0;
            nc_reg         <= 1'b0;
            size_reg       <= '0;
            addr_reg       <= '0;
            store_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (ready_reg && bus.mem_cmd_v_i) begin
                        store_reg      <= bus.mem_cmd_store_i;
                        nc_reg         <= bus.mem_cmd_nc_i;
                        size_reg       <= bus.mem_cmd_size_i;
                        addr_reg       <= bus.mem_cmd_addr_i;
                        store_data_reg <= store_data_next;
                        ready_reg      <= 1'b0;
                        l15_val_reg    <= 1'b1;
                        state_reg      <= REQ;
                    end
                end
                REQ: begin
                    // A return arriving alongside the ack is acked and dropped.
                    if (bus.l15_transducer_ack) begin
                        l15_val_reg <= 1'b0;
                        state_reg   <= WAIT;
                    end
                end
                WAIT: begin
                    if (ret_match) begin
                        resp_v_reg     <= 1'b1;
                        resp_store_reg <= store_reg;
                        resp_data_reg  <= store_reg ? '0 : load_data_next;
                        state_reg      <= RESP;
                    end else if (timeout_hit) begin
                        resp_v_reg     <= 1'b1;
                        resp_store_reg <= store_reg;
                        resp_data_reg  <= data_width_p'(timeout_data_lp);
                        state_reg      <= RESP;
                    end
                end
                RESP: begin
                    // Ready only comes back the cycle after yumi.
                    if (bus.mem_resp_yumi_i) begin
                        resp_v_reg <= 1'b0;
                        ready_reg  <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.mem_cmd_ready_o        = ready_reg;
    assign bus.mem_resp_v_o           = resp_v_reg;
    assign bus.mem_resp_store_o       = resp_store_reg;
    assign bus.mem_resp_data_o        = resp_data_reg;
    assign bus.transducer_l15_val     = l15_val_reg;
    assign bus.transducer_l15_rqtype  = store_reg ? rqtype_store_lp : rqtype_load_lp;
    assign bus.transducer_l15_size    = {1'b0, size_reg};
    assign bus.transducer_l15_address = addr_reg;
    assign bus.transducer_l15_data    = store_data_reg;
    assign bus.transducer_l15_nc      = nc_reg;
    // Every L1.5 return is consumed in the cycle it is presented, whatever the state.
    assign bus.transducer_l15_req_ack = bus.l15_transducer_val;
endmodule

// File: tb/tb_bp_l15_req_engine.sv
// tb_bp_l15_req_engine: directed and randomized transactions checked against a byte-level
// reference model of the command/return rules.
module tb_bp_l15_req_engine;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    bp_l15_req_engine_if #(.addr_width_p(40), .data_width_p(64)) bus ();

    bp_l15_req_engine #(
        .addr_width_p(40), .data_width_p(64), .timeout_cycles_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Observations from the most recent do_txn call.
    logic        obs_accepted, obs_req_stable, obs_nc, obs_junk_acked, obs_junk_dropped;
    logic        obs_ret_acked, obs_resp_v, obs_resp_store, obs_resp_stable, obs_ready_after;
    int          obs_val_cycles;
    logic [4:0]  obs_rqtype;
    logic [2:0]  obs_size;
    logic [39:0] obs_addr;
    logic [63:0] obs_data, obs_resp_data;

    // Reference: each byte lane k carries command byte (k mod 2^size).
    function automatic logic [63:0] model_store_data(input logic [1:0] sz, input logic [63:0] d);
        logic [63:0] r;
        int nbytes;
        nbytes = 1 << sz;
        r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = d[8*(k % nbytes) +: 8];
        return r;
    endfunction

    // Reference: bytes of the addressed 8B half starting at addr[2:0], none past its end.
    function automatic logic [63:0] model_load_data(input logic [39:0] a, input logic [1:0] sz,
                                                    input logic [63:0] d0, input logic [63:0] d1);
        logic [7:0]  blk [16];
        logic [63:0] r;
        int base, off, nbytes;
        for (int k = 0; k < 8; k++) begin
            blk[k]     = d0[8*k +: 8];
            blk[k + 8] = d1[8*k +: 8];
        end
        base   = a[3] ? 8 : 0;
        off    = int'(a[2:0]);
        nbytes = 1 << sz;
        r      = '0;
        for (int i = 0; i < nbytes; i++) if (off + i < 8) r[8*i +: 8] = blk[base + off + i];
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one full transaction and records what the DUT did; tests compare afterwards.
    task automatic do_txn(input logic st, input logic nc, input logic [1:0] sz,
                          input logic [39:0] addr, input logic [63:0] data, input int ack_n,
                          input int ret_delay, input logic [63:0] d0, input logic [63:0] d1,
                          input logic junk_en, input logic [3:0] junk_type, input int yumi_wait);
        obs_accepted = 1'b0;
        for (int c = 0; c < 20 && !obs_accepted; c++) begin
            if (bus.mem_cmd_ready_o === 1'b1) obs_accepted = 1'b1;
            else step();
        end
        bus.mem_cmd_v_i     = 1'b1;
        bus.mem_cmd_store_i = st;
        bus.mem_cmd_nc_i    = nc;
        bus.mem_cmd_size_i  = sz;
        bus.mem_cmd_addr_i  = addr;
        bus.mem_cmd_data_i  = data;
        step();
        bus.mem_cmd_v_i     = 1'b0;
        bus.mem_cmd_addr_i  = {8'($urandom), $urandom};
        bus.mem_cmd_data_i  = rand64();
        bus.mem_cmd_size_i  = 2'($urandom);
        bus.mem_cmd_nc_i    = ~nc;
        bus.mem_cmd_store_i = ~st;
        obs_rqtype     = bus.transducer_l15_rqtype;
        obs_size       = bus.transducer_l15_size;
        obs_addr       = bus.transducer_l15_address;
        obs_data       = bus.transducer_l15_data;
        obs_nc         = bus.transducer_l15_nc;
        obs_val_cycles = 0;
        obs_req_stable = 1'b1;
        for (int c = 0; c < 20 && bus.transducer_l15_val === 1'b1; c++) begin
            if (bus.transducer_l15_rqtype !== obs_rqtype || bus.transducer_l15_size !== obs_size ||
                bus.transducer_l15_address !== obs_addr || bus.transducer_l15_nc !== obs_nc ||
                bus.transducer_l15_data !== obs_data) obs_req_stable = 1'b0;
            obs_val_cycles++;
            if (obs_val_cycles == ack_n) bus.l15_transducer_ack = 1'b1;
            step();
            bus.l15_transducer_ack = 1'b0;
        end
        obs_junk_acked   = 1'b1;
        obs_junk_dropped = 1'b1;
        if (junk_en) begin
            bus.l15_transducer_val        = 1'b1;
            bus.l15_transducer_returntype = junk_type;
            bus.l15_transducer_data_0     = rand64();
            bus.l15_transducer_data_1     = rand64();
            #1;
            obs_junk_acked = bus.transducer_l15_req_ack;
            step();
            bus.l15_transducer_val = 1'b0;
            obs_junk_dropped = (bus.mem_resp_v_o === 1'b0);
        end
        repeat (ret_delay) step();
        bus.l15_transducer_val        = 1'b1;
        bus.l15_transducer_returntype = st ? 4'b0100 : 4'b0000;
        bus.l15_transducer_data_0     = d0;
        bus.l15_transducer_data_1     = d1;
        #1;
        obs_ret_acked = bus.transducer_l15_req_ack;
        step();
        bus.l15_transducer_val    = 1'b0;
        bus.l15_transducer_data_0 = rand64();
        bus.l15_transducer_data_1 = rand64();
        obs_resp_v      = bus.mem_resp_v_o;
        obs_resp_data   = bus.mem_resp_data_o;
        obs_resp_store  = bus.mem_resp_store_o;
        obs_resp_stable = 1'b1;
        for (int i = 0; i <= yumi_wait; i++) begin
            if (i == yumi_wait) bus.mem_resp_yumi_i = 1'b1;
            if (bus.mem_resp_v_o !== 1'b1 || bus.mem_resp_data_o !== obs_resp_data ||
                bus.mem_resp_store_o !== obs_resp_store || bus.mem_cmd_ready_o !== 1'b0)
                obs_resp_stable = 1'b0;
            step();
        end
        bus.mem_resp_yumi_i = 1'b0;
        obs_ready_after = (bus.mem_cmd_ready_o === 1'b1) && (bus.mem_resp_v_o === 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        vectors++;
        if ({bus.mem_cmd_ready_o, bus.mem_resp_v_o, bus.transducer_l15_val, bus.error_o,
             bus.transducer_l15_nc, bus.mem_resp_store_o} !== 6'b0 ||
            bus.transducer_l15_address !== 40'h0 || bus.transducer_l15_data !== 64'h0 ||
            bus.mem_resp_data_o !== 64'h0 || bus.transducer_l15_size !== 3'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b resp_v=%b val=%b addr=%h data=%h, required all 0",
                     bus.mem_cmd_ready_o, bus.mem_resp_v_o, bus.transducer_l15_val,
                     bus.transducer_l15_address, bus.transducer_l15_data);
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if (bus.mem_cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b required 1", bus.mem_cmd_ready_o);
        end
    endtask

    task automatic test_load_8b();
        logic [63:0] d0;
        d0 = rand64();
        do_txn(1'b0, 1'b0, 2'd3, 40'h80_0000_0008, rand64(), 3, 2, d0, 64'h1122334455667788,
               1'b0, 4'h0, 0);
        vectors++;
        if (obs_val_cycles != 3) begin
            miscompares++;
            $display("FAIL load8_val_width: got %0d cycles required 3", obs_val_cycles);
        end
        vectors++;
        if (obs_rqtype !== 5'b00000 || obs_size !== 3'b011 || obs_addr !== 40'h80_0000_0008) begin
            miscompares++;
            $display("FAIL load8_req: rqtype=%b size=%b addr=%h required 00000 011 8000000008",
                     obs_rqtype, obs_size, obs_addr);
        end
        vectors++;
        if (obs_resp_v !== 1'b1 || obs_resp_data !== 64'h1122334455667788 || obs_resp_store !== 1'b0) begin
            miscompares++;
            $display("FAIL load8_resp: v=%b data=%h store=%b required 1 1122334455667788 0",
                     obs_resp_v, obs_resp_data, obs_resp_store);
        end
    endtask

    task automatic test_load_1b();
        do_txn(1'b0, 1'b0, 2'd0, 40'h12_3456_7005, rand64(), 1, 0, 64'h0706050403020100, rand64(),
               1'b0, 4'h0, 0);
        vectors++;
        if (obs_val_cycles != 1 || obs_size !== 3'b000) begin
            miscompares++;
            $display("FAIL load1_req: val cycles=%0d size=%b required 1 000", obs_val_cycles, obs_size);
        end
        vectors++;
        if (obs_resp_data !== 64'h05 || obs_resp_store !== 1'b0) begin
            miscompares++;
            $display("FAIL load1_resp: data=%h store=%b required 0000000000000005 0",
                     obs_resp_data, obs_resp_store);
        end
    endtask

    task automatic test_store_2b();
        do_txn(1'b1, 1'b1, 2'd1, 40'h34_0000_1002, {$urandom, 16'($urandom), 16'hABCD}, 2, 1,
               rand64(), rand64(), 1'b0, 4'h0, 0);
        vectors++;
        if (obs_data !== 64'hABCDABCDABCDABCD || obs_size !== 3'b001 || obs_nc !== 1'b1 ||
            obs_rqtype !== 5'b00001) begin
            miscompares++;
            $display("FAIL store2_req: data=%h size=%b nc=%b rqtype=%b required ABCDABCDABCDABCD 001 1 00001",
                     obs_data, obs_size, obs_nc, obs_rqtype);
        end
        vectors++;
        if (obs_resp_v !== 1'b1 || obs_resp_store !== 1'b1 || obs_resp_data !== 64'h0) begin
            miscompares++;
            $display("FAIL store2_resp: v=%b store=%b data=%h required 1 1 0", obs_resp_v,
                     obs_resp_store, obs_resp_data);
        end
    endtask

    task automatic test_unsolicited();
        logic [63:0] d0;
        bus.l15_transducer_val        = 1'b1;
        bus.l15_transducer_returntype = 4'b0011;
        #1;
        vectors++;
        if (bus.transducer_l15_req_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL unsol_idle_ack: got %b required 1", bus.transducer_l15_req_ack);
        end
        step();
        bus.l15_transducer_val = 1'b0;
        vectors++;
        if (bus.mem_cmd_ready_o !== 1'b1 || bus.mem_resp_v_o !== 1'b0 || bus.transducer_l15_val !== 1'b0) begin
            miscompares++;
            $display("FAIL unsol_idle_state: ready=%b resp_v=%b val=%b required 1 0 0",
                     bus.mem_cmd_ready_o, bus.mem_resp_v_o, bus.transducer_l15_val);
        end
        d0 = rand64();
        do_txn(1'b0, 1'b0, 2'd2, 40'h00_0000_0104, rand64(), 2, 2, d0, rand64(), 1'b1, 4'b0011, 0);
        vectors++;
        if (obs_junk_acked !== 1'b1 || obs_junk_dropped !== 1'b1) begin
            miscompares++;
            $display("FAIL unsol_wait: acked=%b dropped=%b required 1 1", obs_junk_acked, obs_junk_dropped);
        end
        vectors++;
        if (obs_resp_data !== {32'h0, d0[63:32]}) begin
            miscompares++;
            $display("FAIL unsol_followup: data=%h required %h", obs_resp_data, {32'h0, d0[63:32]});
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d1;
        d1 = rand64();
        do_txn(1'b0, 1'b0, 2'd3, 40'h55_0000_0008, rand64(), 1, 0, rand64(), d1, 1'b0, 4'h0, 10);
        vectors++;
        if (obs_resp_stable !== 1'b1 || obs_resp_data !== d1) begin
            miscompares++;
            $display("FAIL backpressure_hold: stable=%b data=%h required 1 %h", obs_resp_stable,
                     obs_resp_data, d1);
        end
        vectors++;
        if (obs_ready_after !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release: ready/idle after yumi=%b required 1", obs_ready_after);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 20 && bus.mem_cmd_ready_o !== 1'b1; c++) step();
        bus.mem_cmd_v_i     = 1'b1;
        bus.mem_cmd_store_i = 1'b1;
        bus.mem_cmd_nc_i    = 1'b1;
        bus.mem_cmd_size_i  = 2'd3;
        bus.mem_cmd_addr_i  = 40'hFF_FFFF_FFF8;
        bus.mem_cmd_data_i  = rand64();
        step();
        bus.mem_cmd_v_i = 1'b0;
        vectors++;
        if (bus.transducer_l15_val !== 1'b1) begin
            miscompares++;
            $display("FAIL resetmid_req: val=%b required 1", bus.transducer_l15_val);
        end
        reset_n = 1'b0;
        step();
        vectors++;
        if ({bus.mem_cmd_ready_o, bus.mem_resp_v_o, bus.transducer_l15_val, bus.transducer_l15_nc,
             bus.transducer_l15_req_ack} !== 5'b0 || bus.transducer_l15_address !== 40'h0 ||
            bus.transducer_l15_data !== 64'h0 || bus.transducer_l15_rqtype !== 5'b0 ||
            bus.transducer_l15_size !== 3'b0) begin
            miscompares++;
            $display("FAIL resetmid_outputs: val=%b addr=%h data=%h rqtype=%b size=%b required all 0",
                     bus.transducer_l15_val, bus.transducer_l15_address, bus.transducer_l15_data,
                     bus.transducer_l15_rqtype, bus.transducer_l15_size);
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if (bus.mem_cmd_ready_o !== 1'b1 || bus.transducer_l15_val !== 1'b0) begin
            miscompares++;
            $display("FAIL resetmid_idle: ready=%b val=%b required 1 0", bus.mem_cmd_ready_o,
                     bus.transducer_l15_val);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic        st, nc, je;
            logic [1:0]  sz;
            logic [39:0] addr;
            logic [63:0] data, d0, d1, exp_resp;
            logic [3:0]  jt, match;
            int          ack_n;
            st    = 1'($urandom);
            nc    = 1'($urandom);
            sz    = 2'($urandom);
            addr  = {8'($urandom), $urandom};
            data  = rand64();
            d0    = rand64();
            d1    = rand64();
            ack_n = $urandom_range(1, 4);
            je    = 1'($urandom);
            match = st ? 4'b0100 : 4'b0000;
            jt    = 4'($urandom);
            if (jt == match) jt = st ? 4'b0000 : 4'b0100;
            do_txn(st, nc, sz, addr, data, ack_n, $urandom_range(0, 5), d0, d1, je, jt,
                   $urandom_range(0, 3));
            exp_resp = st ? 64'h0 : model_load_data(addr, sz, d0, d1);
            vectors++;
            if (obs_accepted !== 1'b1 || obs_val_cycles != ack_n || obs_req_stable !== 1'b1) begin
                miscompares++;
                $display("FAIL rnd%0d handshake: acc=%b val cycles=%0d stable=%b required 1 %0d 1",
                         n, obs_accepted, obs_val_cycles, obs_req_stable, ack_n);
            end
            vectors++;
            if (obs_rqtype !== {4'b0, st} || obs_size !== {1'b0, sz} || obs_addr !== addr || obs_nc !== nc) begin
                miscompares++;
                $display("FAIL rnd%0d req_fields: rqtype=%b size=%b addr=%h nc=%b required %b %b %h %b",
                         n, obs_rqtype, obs_size, obs_addr, obs_nc, {4'b0, st}, {1'b0, sz}, addr, nc);
            end
            if (st) begin
                vectors++;
                if (obs_data !== model_store_data(sz, data)) begin
                    miscompares++;
                    $display("FAIL rnd%0d store_data: got %h required %h", n, obs_data,
                             model_store_data(sz, data));
                end
            end
            vectors++;
            if (obs_junk_acked !== 1'b1 || obs_junk_dropped !== 1'b1 || obs_ret_acked !== 1'b1) begin
                miscompares++;
                $display("FAIL rnd%0d returns: junk acked=%b dropped=%b ret acked=%b required 1 1 1",
                         n, obs_junk_acked, obs_junk_dropped, obs_ret_acked);
            end
            vectors++;
            if (obs_resp_v !== 1'b1 || obs_resp_data !== exp_resp || obs_resp_store !== st) begin
                miscompares++;
                $display("FAIL rnd%0d resp: v=%b data=%h store=%b required 1 %h %b", n, obs_resp_v,
                         obs_resp_data, obs_resp_store, exp_resp, st);
            end
            vectors++;
            if (obs_resp_stable !== 1'b1 || obs_ready_after !== 1'b1) begin
                miscompares++;
                $display("FAIL rnd%0d resp_handoff: stable=%b ready after=%b required 1 1", n,
                         obs_resp_stable, obs_ready_after);
            end
        end
    endtask

`ifdef BP_L15_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        for (int c = 0; c < 20 && bus.mem_cmd_ready_o !== 1'b1; c++) step();
        bus.mem_cmd_v_i     = 1'b1;
        bus.mem_cmd_store_i = 1'b0;
        bus.mem_cmd_size_i  = 2'd3;
        bus.mem_cmd_addr_i  = 40'h10_0000_0000;
        step();
        bus.mem_cmd_v_i        = 1'b0;
        bus.l15_transducer_ack = 1'b1;
        step();
        bus.l15_transducer_ack = 1'b0;
        vectors++;
        if (bus.error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: error=%b required 0", bus.error_o);
        end
        n = 0;
        while (n < 100 && bus.mem_resp_v_o !== 1'b1) begin
            n++;
            step();
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL timeout_cycles: waited %0d cycles required 16", n);
        end
        vectors++;
        if (bus.error_o !== 1'b1 || bus.mem_resp_data_o !== 64'hDEADBEEFDEADBEEF) begin
            miscompares++;
            $display("FAIL timeout_resp: error=%b data=%h required 1 DEADBEEFDEADBEEF", bus.error_o,
                     bus.mem_resp_data_o);
        end
        bus.mem_resp_yumi_i = 1'b1;
        step();
        bus.mem_resp_yumi_i = 1'b0;
        step();
        vectors++;
        if (bus.error_o !== 1'b1 || bus.mem_cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: error=%b ready=%b required 1 1", bus.error_o, bus.mem_cmd_ready_o);
        end
    endtask
`else
    task automatic test_no_timeout();
        logic seen;
        do_txn(1'b0, 1'b0, 2'd3, 40'h20_0000_0000, rand64(), 1, 40, 64'h0123456789ABCDEF, rand64(),
               1'b0, 4'h0, 0);
        seen = obs_resp_v;
        vectors++;
        if (seen !== 1'b1 || obs_resp_data !== 64'h0123456789ABCDEF) begin
            miscompares++;
            $display("FAIL long_wait_resp: v=%b data=%h required 1 0123456789ABCDEF", seen, obs_resp_data);
        end
        vectors++;
        if (bus.error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL long_wait_error: error=%b required 0", bus.error_o);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_cmd_v_i               = 1'b0;
        bus.mem_cmd_store_i           = 1'b0;
        bus.mem_cmd_nc_i              = 1'b0;
        bus.mem_cmd_size_i            = 2'd0;
        bus.mem_cmd_addr_i            = '0;
        bus.mem_cmd_data_i            = '0;
        bus.mem_resp_yumi_i           = 1'b0;
        bus.l15_transducer_ack        = 1'b0;
        bus.l15_transducer_header_ack = 1'b0;
        bus.l15_transducer_val        = 1'b0;
        bus.l15_transducer_returntype = 4'h0;
        bus.l15_transducer_data_0     = '0;
        bus.l15_transducer_data_1     = '0;
        test_reset();
        test_load_8b();
        test_load_1b();
        test_store_2b();
        test_unsolicited();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef BP_L15_REQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
